// File: rtl/answer_checker_if.sv
// Bundle between the quiz question/button front end and the answer checker.
// The checker is the slave: it takes the question and button pulses and drives the display/score signals.
interface answer_checker_if;
  logic [3:0] num_left;
  logic [3:0] num_right;
  logic [3:0] operater;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       neg_toggle;
  logic       clear;
  logic       submit;
  logic [3:0] ans_tens;
  logic [3:0] ans_ones;
  logic       ans_neg;
  logic       correct;
  logic       wrong;
  logic       next_q;
  logic [6:0] score;
  logic [2:0] lives;
  logic       game_over;

  modport master (
    output num_left, num_right, operater, digit_in,
    output digit_valid, neg_toggle, clear, submit,
    input  ans_tens, ans_ones, ans_neg, correct, wrong,
    input  next_q, score, lives, game_over
  );

  modport slave (
    input  num_left, num_right, operater, digit_in,
    input  digit_valid, neg_toggle, clear, submit,
    output ans_tens, ans_ones, ans_neg, correct, wrong,
    output next_q, score, lives, game_over
  );
endinterface

// File: rtl/answer_checker.sv
// Quiz answer checker: collects a signed two-digit answer, computes the expected result
// of the displayed question, scores it, and tracks lives / game over.
module answer_checker #(
  parameter int RESULT_HOLD = 16,
  parameter int LIVES       = 3,
  parameter int MAX_SCORE   = 99
) (
  input  logic              clk,
  input  logic              rst_n,
  answer_checker_if.slave   bus
);

  localparam int HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    CALC  = 3'd1,
    CHECK = 3'd2,
    SHOW  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [3:0]        ans_tens_reg;
  logic [3:0]        ans_ones_reg;
  logic              ans_neg_reg;
  logic              correct_reg;
  logic              wrong_reg;
  logic              next_q_reg;
  logic [6:0]        score_reg;
  logic [2:0]        lives_reg;
  logic              game_over_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [7:0]        expected_reg;
  logic              op_err_reg;

  logic              hold_done;
  logic              entry_en;
  logic              calc_en;
  logic              check_en;
  logic              show_en;
  logic [7:0]        expected_calc;
  logic              op_err_calc;
  logic [7:0]        entered_mag;
  logic [7:0]        entered_val;

  assign hold_done = (hold_reg == HOLD_W'(RESULT_HOLD - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ENTRY;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ENTRY:   if (bus.submit) state_next = CALC;
      CALC:    state_next = CHECK;
      CHECK:   state_next = SHOW;
      SHOW:    if (hold_done) state_next = (lives_reg == 3'd0) ? OVER : ENTRY;
      OVER:    state_next = OVER;
      default: state_next = ENTRY;
    endcase
  end

  // Per-state datapath enables
  always_comb begin
    entry_en = 1'b0;
    calc_en  = 1'b0;
    check_en = 1'b0;
    show_en  = 1'b0;
    case (state_reg)
      ENTRY:   entry_en = 1'b1;
      CALC:    calc_en  = 1'b1;
      CHECK:   check_en = 1'b1;
      SHOW:    show_en  = 1'b1;
      default: ;
    endcase
  end

  // Expected result as signed 8-bit; operands are 0..9 so every legal result fits.
  always_comb begin
    expected_calc = 8'd0;
    op_err_calc   = 1'b0;
    case (bus.operater)
      4'b1000: expected_calc = 8'(bus.num_left) + 8'(bus.num_right);
      4'b0100: expected_calc = 8'(bus.num_left) * 8'(bus.num_right);
      4'b0010: expected_calc = 8'(bus.num_left) - 8'(bus.num_right);
      4'b0001: begin
        if (bus.num_right == 4'd0) op_err_calc = 1'b1;
        else                       expected_calc = 8'(bus.num_left / bus.num_right);
      end
      default: op_err_calc = 1'b1;
    endcase
  end

  // Two's complement negation makes -0 compare equal to 0.
  assign entered_mag = 8'(ans_tens_reg) * 8'd10 + 8'(ans_ones_reg);
  assign entered_val = ans_neg_reg ? (8'd0 - entered_mag) : entered_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans_tens_reg  <= 4'd0;
      ans_ones_reg  <= 4'd0;
      ans_neg_reg   <= 1'b0;
      correct_reg   <= 1'b0;
      wrong_reg     <= 1'b0;
      next_q_reg    <= 1'b0;
      score_reg     <= 7'd0;
      lives_reg     <= 3'(LIVES);
      game_over_reg <= 1'b0;
      hold_reg      <= '0;
      expected_reg  <= 8'd0;
      op_err_reg    <= 1'b0;
    end else begin
      next_q_reg <= 1'b0;

      // Button priority: submit > clear > digit_valid > neg_toggle.
      if (entry_en) begin
        if (bus.submit) begin
          ans_tens_reg <= ans_tens_reg;
        end else if (bus.clear) begin
          ans_tens_reg <= 4'd0;
          ans_ones_reg <= 4'd0;
          ans_neg_reg  <= 1'b0;
        end else if (bus.digit_valid) begin
          if (bus.digit_in <= 4'd9) begin
            ans_tens_reg <= ans_ones_reg;
            ans_ones_reg <= bus.digit_in;
          end
        end else if (bus.neg_toggle) begin
          ans_neg_reg <= ~ans_neg_reg;
        end
      end

      if (calc_en) begin
        expected_reg <= expected_calc;
        op_err_reg   <= op_err_calc;
      end

      if (check_en) begin
        hold_reg <= '0;
        if ((entered_val == expected_reg) && !op_err_reg) begin
          correct_reg <= 1'b1;
          if (score_reg < 7'(MAX_SCORE)) score_reg <= score_reg + 7'd1;
        end else begin
          wrong_reg <= 1'b1;
          lives_reg <= lives_reg - 3'd1;
        end
      end

      if (show_en) begin
        if (hold_done) begin
          correct_reg  <= 1'b0;
          wrong_reg    <= 1'b0;
          ans_tens_reg <= 4'd0;
          ans_ones_reg <= 4'd0;
          ans_neg_reg  <= 1'b0;
          if (lives_reg != 3'd0) next_q_reg    <= 1'b1;
          else                   game_over_reg <= 1'b1;
        end else begin
          hold_reg <= hold_reg + HOLD_W'(1);
        end
      end
    end
  end

  assign bus.ans_tens  = ans_tens_reg;
  assign bus.ans_ones  = ans_ones_reg;
  assign bus.ans_neg   = ans_neg_reg;
  assign bus.correct   = correct_reg;
  assign bus.wrong     = wrong_reg;
  assign bus.next_q    = next_q_reg;
  assign bus.score     = score_reg;
  assign bus.lives     = lives_reg;
  assign bus.game_over = game_over_reg;

endmodule

// File: tb/tb_answer_checker.sv
// Directed bench for answer_checker: scenario tasks with hand-computed expectations.
module tb_answer_checker;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  answer_checker_if bus();

  answer_checker #(
    .RESULT_HOLD(16),
    .LIVES(3),
    .MAX_SCORE(99)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of button pulses, then release them.
  task automatic press(input logic [3:0] d, input logic dv, input logic nt,
                       input logic clr, input logic sub);
    bus.digit_in    = d;
    bus.digit_valid = dv;
    bus.neg_toggle  = nt;
    bus.clear       = clr;
    bus.submit      = sub;
    step;
    bus.digit_valid = 1'b0;
    bus.neg_toggle  = 1'b0;
    bus.clear       = 1'b0;
    bus.submit      = 1'b0;
  endtask

  task automatic question(input logic [3:0] l, input logic [3:0] r, input logic [3:0] op);
    bus.num_left  = l;
    bus.num_right = r;
    bus.operater  = op;
  endtask

  // Observe the result window after a submit; the question is scrambled once CALC is past.
  task automatic watch(output logic early, output logic [1:0] cw, output int hi, output int nq);
    step;
    early = bus.correct | bus.wrong;
    bus.num_left = 4'hF;
    bus.operater = 4'b0000;
    step;
    cw = {bus.correct, bus.wrong};
    hi = (bus.correct | bus.wrong) ? 1 : 0;
    nq = 0;
    for (int i = 0; i < 24; i++) begin
      step;
      if (bus.correct | bus.wrong) hi++;
      if (bus.next_q) nq++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    question(4'd0, 4'd0, 4'b1000);
    bus.digit_in = 4'd0;
    bus.digit_valid = 1'b0;
    bus.neg_toggle = 1'b0;
    bus.clear = 1'b0;
    bus.submit = 1'b0;
    step;
    step;
    checks++;
    if (bus.lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", bus.lives); end
    checks++;
    if (bus.score !== 7'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score); end
    checks++;
    if ({bus.correct, bus.wrong, bus.next_q, bus.game_over, bus.ans_neg} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {bus.correct, bus.wrong, bus.next_q, bus.game_over, bus.ans_neg});
    end
    checks++;
    if ({bus.ans_tens, bus.ans_ones} !== 8'h00) begin
      errors++; $display("FAIL reset_digits: got %h want 00", {bus.ans_tens, bus.ans_ones});
    end
    rst_n = 1'b1;
    $display("txn reset: lives=%0d score=%0d", bus.lives, bus.score);
  endtask

  task automatic test_add;
    logic early; logic [1:0] cw; int hi; int nq;
    question(4'd8, 4'd2, 4'b1000);
    press(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.ans_tens, bus.ans_ones} !== 8'h10) begin
      errors++; $display("FAIL add_entry: got %h want 10", {bus.ans_tens, bus.ans_ones});
    end
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn add 8+2 ans 10: cw=%b hold=%0d next_q=%0d score=%0d", cw, hi, nq, bus.score);
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL add_latency_early: got %b want 0", early); end
    checks++;
    if (cw !== 2'b10) begin errors++; $display("FAIL add_result: got %b want 10", cw); end
    checks++;
    if (hi !== 16) begin errors++; $display("FAIL add_hold: got %0d want 16", hi); end
    checks++;
    if (nq !== 1) begin errors++; $display("FAIL add_next_q: got %0d want 1", nq); end
    checks++;
    if (bus.score !== 7'd1) begin errors++; $display("FAIL add_score: got %0d want 1", bus.score); end
    checks++;
    if ({bus.ans_tens, bus.ans_ones} !== 8'h00) begin
      errors++; $display("FAIL add_entry_cleared: got %h want 00", {bus.ans_tens, bus.ans_ones});
    end
  endtask

  task automatic test_sub_neg;
    logic early; logic [1:0] cw; int hi; int nq;
    question(4'd4, 4'd5, 4'b0010);
    press(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.ans_neg, bus.ans_ones} !== 5'b1_0001) begin
      errors++; $display("FAIL sub_entry: got neg=%b ones=%0d want neg=1 ones=1", bus.ans_neg, bus.ans_ones);
    end
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn sub 4-5 ans -1: cw=%b hold=%0d next_q=%0d score=%0d", cw, hi, nq, bus.score);
    checks++;
    if (cw !== 2'b10) begin errors++; $display("FAIL sub_result: got %b want 10", cw); end
    checks++;
    if (bus.score !== 7'd2) begin errors++; $display("FAIL sub_score: got %0d want 2", bus.score); end
    checks++;
    if (bus.ans_neg !== 1'b0) begin errors++; $display("FAIL sub_neg_cleared: got %b want 0", bus.ans_neg); end
  endtask

  task automatic test_div;
    logic early; logic [1:0] cw; int hi; int nq;
    question(4'd5, 4'd3, 4'b0001);
    press(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn div 5/3 ans 1: cw=%b next_q=%0d score=%0d", cw, nq, bus.score);
    checks++;
    if (cw !== 2'b10) begin errors++; $display("FAIL div_result: got %b want 10", cw); end
    checks++;
    if (bus.score !== 7'd3) begin errors++; $display("FAIL div_score: got %0d want 3", bus.score); end

    question(4'd7, 4'd0, 4'b0001);
    press(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn div 7/0 ans 0: cw=%b hold=%0d next_q=%0d lives=%0d", cw, hi, nq, bus.lives);
    checks++;
    if (cw !== 2'b01) begin errors++; $display("FAIL div0_result: got %b want 01", cw); end
    checks++;
    if (hi !== 16) begin errors++; $display("FAIL div0_hold: got %0d want 16", hi); end
    checks++;
    if (nq !== 1) begin errors++; $display("FAIL div0_next_q: got %0d want 1", nq); end
    checks++;
    if (bus.lives !== 3'd2) begin errors++; $display("FAIL div0_lives: got %0d want 2", bus.lives); end
    checks++;
    if (bus.score !== 7'd3) begin errors++; $display("FAIL div0_score: got %0d want 3", bus.score); end
  endtask

  task automatic test_entry_edges;
    logic early; logic [1:0] cw; int hi; int nq;
    press(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.ans_neg, bus.ans_tens, bus.ans_ones} !== 9'h000) begin
      errors++; $display("FAIL clear_entry: got %h want 000", {bus.ans_neg, bus.ans_tens, bus.ans_ones});
    end
    press(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.ans_tens, bus.ans_ones} !== 8'h03) begin
      errors++; $display("FAIL digit_gt9: got %h want 03", {bus.ans_tens, bus.ans_ones});
    end
    question(4'd1, 4'd2, 4'b1000);
    press(4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.ans_tens, bus.ans_ones} !== 8'h03) begin
      errors++; $display("FAIL submit_drops_digit: got %h want 03", {bus.ans_tens, bus.ans_ones});
    end
    watch(early, cw, hi, nq);
    $display("txn add 1+2 ans 3 (digit+submit): cw=%b score=%0d", cw, bus.score);
    checks++;
    if (cw !== 2'b10) begin errors++; $display("FAIL priority_result: got %b want 10", cw); end
    checks++;
    if (bus.score !== 7'd4) begin errors++; $display("FAIL priority_score: got %0d want 4", bus.score); end
  endtask

  task automatic test_mul;
    logic early; logic [1:0] cw; int hi; int nq;
    question(4'd9, 4'd9, 4'b0100);
    press(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn mul 9*9 ans 81: cw=%b score=%0d", cw, bus.score);
    checks++;
    if (cw !== 2'b10) begin errors++; $display("FAIL mul_result: got %b want 10", cw); end
    checks++;
    if (bus.score !== 7'd5) begin errors++; $display("FAIL mul_score: got %0d want 5", bus.score); end
  endtask

  task automatic test_reset_mid_show;
    int nq;
    int hi;
    question(4'd2, 4'd3, 4'b1000);
    press(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step;
    step;
    checks++;
    if (bus.correct !== 1'b1) begin errors++; $display("FAIL midshow_pre: got %b want 1", bus.correct); end
    step; step; step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    $display("txn reset mid-show: correct=%b score=%0d lives=%0d", bus.correct, bus.score, bus.lives);
    checks++;
    if ({bus.correct, bus.wrong, bus.next_q} !== 3'b000) begin
      errors++; $display("FAIL midshow_flags: got %b want 000", {bus.correct, bus.wrong, bus.next_q});
    end
    checks++;
    if (bus.score !== 7'd0) begin errors++; $display("FAIL midshow_score: got %0d want 0", bus.score); end
    checks++;
    if (bus.lives !== 3'd3) begin errors++; $display("FAIL midshow_lives: got %0d want 3", bus.lives); end
    nq = 0;
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      step;
      if (bus.next_q) nq++;
      if (bus.correct | bus.wrong) hi++;
    end
    checks++;
    if (nq !== 0 || hi !== 0) begin
      errors++; $display("FAIL midshow_quiet: got next_q=%0d hold=%0d want 0 0", nq, hi);
    end
    press(4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ans_ones !== 4'd4) begin errors++; $display("FAIL midshow_entry: got %0d want 4", bus.ans_ones); end
    press(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_game_over;
    logic early; logic [1:0] cw; int hi; int nq;
    question(4'd2, 4'd2, 4'b1000);
    press(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn wrong1 2+2 ans 5: cw=%b next_q=%0d lives=%0d", cw, nq, bus.lives);
    checks++;
    if (cw !== 2'b01 || nq !== 1 || bus.lives !== 3'd2) begin
      errors++; $display("FAIL wrong1: got cw=%b nq=%0d lives=%0d want 01 1 2", cw, nq, bus.lives);
    end

    question(4'd3, 4'd3, 4'b0011);
    press(4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn wrong2 bad op ans 6: cw=%b next_q=%0d lives=%0d", cw, nq, bus.lives);
    checks++;
    if (cw !== 2'b01 || nq !== 1 || bus.lives !== 3'd1) begin
      errors++; $display("FAIL wrong2_operr: got cw=%b nq=%0d lives=%0d want 01 1 1", cw, nq, bus.lives);
    end

    question(4'd0, 4'd0, 4'b0000);
    press(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn wrong3 op 0000: cw=%b hold=%0d next_q=%0d lives=%0d over=%b",
             cw, hi, nq, bus.lives, bus.game_over);
    checks++;
    if (cw !== 2'b01 || hi !== 16) begin
      errors++; $display("FAIL wrong3_result: got cw=%b hold=%0d want 01 16", cw, hi);
    end
    checks++;
    if (nq !== 0) begin errors++; $display("FAIL over_next_q: got %0d want 0", nq); end
    checks++;
    if (bus.lives !== 3'd0 || bus.game_over !== 1'b1) begin
      errors++; $display("FAIL over_state: got lives=%0d over=%b want 0 1", bus.lives, bus.game_over);
    end

    question(4'd1, 4'd1, 4'b1000);
    press(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ans_ones !== 4'd0) begin errors++; $display("FAIL over_entry_ignored: got %0d want 0", bus.ans_ones); end
    press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch(early, cw, hi, nq);
    $display("txn submit in OVER: cw=%b hold=%0d next_q=%0d", cw, hi, nq);
    checks++;
    if (cw !== 2'b00 || hi !== 0 || nq !== 0) begin
      errors++; $display("FAIL over_submit_ignored: got cw=%b hold=%0d nq=%0d want 00 0 0", cw, hi, nq);
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.score !== 7'd0) begin
      errors++; $display("FAIL over_hold: got over=%b score=%0d want 1 0", bus.game_over, bus.score);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_add;
    test_sub_neg;
    test_div;
    test_entry_edges;
    test_mul;
    test_reset_mid_show;
    test_game_over;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
